// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: round count, S-box, the bit-level round
// primitives and the known-answer vectors used by the encrypt/decrypt benches.
package present_pkg;

    localparam int NR_ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Known-answer vectors: {key, plaintext, ciphertext}
    localparam logic [79:0] KAT_KEY [4] = '{
        80'h0000_0000_0000_0000_0000, 80'hFFFF_FFFF_FFFF_FFFF_FFFF,
        80'h0000_0000_0000_0000_0000, 80'hFFFF_FFFF_FFFF_FFFF_FFFF
    };
    localparam logic [63:0] KAT_PT [4] = '{
        64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF
    };
    localparam logic [63:0] KAT_CT [4] = '{
        64'h5579_C138_7B22_8445, 64'hE72C_46C0_F594_5049,
        64'hA112_FFC7_2F68_417B, 64'h3333_DCD3_2132_10D2
    };

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox4(x[4*n +: 4]);
        end
        return r;
    endfunction

    // Bit i lands on (16*i) mod 63; bit 63 is a fixed point.
    function automatic logic [63:0] player64(input logic [63:0] x);
        logic [63:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 63; i++) begin
            src    = 6'(i);
            dst    = 6'((16 * i) % 63);
            r[dst] = x[src];
        end
        r[63] = x[63];
        return r;
    endfunction

    // Key schedule step: rotate left 61, S-box the top nibble, xor the round counter.
    function automatic logic [79:0] key_update80(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_round.sv
// One PRESENT round without the key schedule: add round key, S-box layer, pLayer.
module present_round
    import present_pkg::*;
(
    input  logic [63:0] state_i,
    input  logic [63:0] rkey_i,
    output logic [63:0] t_o
);

    assign t_o = player64(sbox_layer64(state_i ^ rkey_i));

endmodule

// File: rtl/present_encoder.sv
// Iterative PRESENT-80 encryption core: one round per clock, valid/ready on
// both sides, final K32 whitening folded into the last round cycle.
module present_encoder
    import present_pkg::*;
#(
    parameter int NR_ROUNDS = present_pkg::NR_ROUNDS,
    parameter int KEY_W     = 80,
    parameter int BLK_W     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] plaintext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] ciphertext,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // rc carries one extra bit so it cannot wrap inside a block.
    localparam logic [5:0] RC_LAST = 6'(NR_ROUNDS);

    state_e      state_q, state_d;
    logic [5:0]  rc_q, rc_d;
    logic [79:0] key_q, key_d;
    logic [63:0] ct_q, ct_d;
    logic        ov_q, ov_d;
    logic [63:0] st_q, st_d;
    logic [79:0] rk_q, rk_d;

    logic [63:0] t;
    logic [79:0] rk_next;
    logic        accept;
    logic        last;

    present_round u_round (
        .state_i (st_q),
        .rkey_i  (rk_q[79:16]),
        .t_o     (t)
    );

    assign rk_next = key_update80(rk_q, rc_q[4:0]);
    assign accept  = in_valid && (state_q == IDLE);
    assign last    = (rc_q == RC_LAST);

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign out_valid  = ov_q;
    assign ciphertext = ct_q;

    // Next-state logic for the FSM, counter, key register and datapath.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        key_d   = key_q;
        ct_d    = ct_q;
        ov_d    = ov_q;
        st_d    = st_q;
        rk_d    = rk_q;
        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d = key_in;
                end
                if (accept) begin
                    st_d    = plaintext;
                    rk_d    = key_load ? key_in : key_q;
                    rc_d    = 6'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d = t;
                rk_d = rk_next;
                rc_d = rc_q + 6'd1;
                if (last) begin
                    ct_d    = t ^ rk_next[79:16];
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rc_q    <= 6'd1;
            key_q   <= '0;
            ct_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            ov_q    <= ov_d;
        end
    end

    // Round datapath; its contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        st_q <= st_d;
        rk_q <= rk_d;
    end

endmodule
